// File: rtl/axil_addr_router.sv
// 1-to-N AXI4-Lite address router. The selector field picks the slave, and the field is cleared in the forwarded address.
// Define AXIL_ROUTER_TIMEOUT_EN to add a per-FSM watchdog that answers SLVERR when a slave stalls.
module axil_addr_router #(
    parameter int N_SLAVES = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int SEL_HI   = 31,
    parameter int SEL_LO   = 24,
    parameter logic [N_SLAVES*(SEL_HI-SEL_LO+1)-1:0] SLAVE_ID = {8'hFF, 8'h00}
`ifdef AXIL_ROUTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT  = 1023
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_W-1:0]              s_araddr,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    output logic [DATA_W-1:0]              s_rdata,
    output logic [1:0]                     s_rresp,
    output logic                           s_rvalid,
    input  logic                           s_rready,
    input  logic [ADDR_W-1:0]              s_awaddr,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [DATA_W-1:0]              s_wdata,
    input  logic [DATA_W/8-1:0]            s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    output logic [1:0]                     s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    output logic [N_SLAVES*ADDR_W-1:0]     m_araddr,
    output logic [N_SLAVES-1:0]            m_arvalid,
    input  logic [N_SLAVES-1:0]            m_arready,
    input  logic [N_SLAVES*DATA_W-1:0]     m_rdata,
    input  logic [N_SLAVES*2-1:0]          m_rresp,
    input  logic [N_SLAVES-1:0]            m_rvalid,
    output logic [N_SLAVES-1:0]            m_rready,
    output logic [N_SLAVES*ADDR_W-1:0]     m_awaddr,
    output logic [N_SLAVES-1:0]            m_awvalid,
    input  logic [N_SLAVES-1:0]            m_awready,
    output logic [N_SLAVES*DATA_W-1:0]     m_wdata,
    output logic [N_SLAVES*DATA_W/8-1:0]   m_wstrb,
    output logic [N_SLAVES-1:0]            m_wvalid,
    input  logic [N_SLAVES-1:0]            m_wready,
    input  logic [N_SLAVES*2-1:0]          m_bresp,
    input  logic [N_SLAVES-1:0]            m_bvalid,
    output logic [N_SLAVES-1:0]            m_bready
);
    localparam int SELW = SEL_HI - SEL_LO + 1;
    localparam int IW   = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam logic [N_SLAVES-1:0] ONE = N_SLAVES'(1);

    localparam logic [1:0] R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2, R_RESP = 2'd3;
    localparam logic [1:0] W_IDLE = 2'd0, W_FWD  = 2'd1, W_BWAIT = 2'd2, W_RESP = 2'd3;

    // MSB = hit; lower bits = lowest matching slave index.
    function automatic logic [IW:0] decode(input logic [ADDR_W-1:0] a);
        logic [IW:0] r;
        r = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--)
            if (a[SEL_HI:SEL_LO] == SLAVE_ID[i*SELW +: SELW]) r = {1'b1, IW'(i)};
        return r;
    endfunction

    logic [1:0]          rstate_q, rstate_d;
    logic [IW-1:0]       rsel_q, rsel_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic                arready_q, arready_d, rvalid_q, rvalid_d;
    logic [N_SLAVES-1:0] marvalid_q, marvalid_d, mrready_q, mrready_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [IW:0]         rdec;

    logic [1:0]          wstate_q, wstate_d;
    logic [IW-1:0]       wsel_q, wsel_d;
    logic                whit_q, whit_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [N_SLAVES-1:0] mawvalid_q, mawvalid_d, mwvalid_q, mwvalid_d, mbready_q, mbready_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [IW:0]         wdec;
    logic                aw_hs, w_hs;
    logic [N_SLAVES-1:0] awv_n, wv_n;

`ifdef AXIL_ROUTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] rcnt_q, rcnt_d, wcnt_q, wcnt_d;
    logic          rto, wto;
    assign rto = (rcnt_q == TW'(TIMEOUT - 1));
    assign wto = (wcnt_q == TW'(TIMEOUT - 1));
`endif

    always_comb begin
        rstate_d   = rstate_q;
        rsel_d     = rsel_q;
        raddr_d    = raddr_q;
        arready_d  = arready_q;
        marvalid_d = marvalid_q;
        mrready_d  = mrready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rdec       = decode(s_araddr);
        case (rstate_q)
            R_IDLE: if (s_arvalid && arready_q) begin
                arready_d = 1'b0;
                raddr_d   = s_araddr;
                raddr_d[SEL_HI:SEL_LO] = '0;
                rsel_d    = rdec[IW-1:0];
                if (rdec[IW]) begin
                    marvalid_d = ONE << rdec[IW-1:0];
                    rstate_d   = R_ADDR;
                end else begin
                    rvalid_d = 1'b1;
                    rdata_d  = '0;
                    rresp_d  = 2'b11;
                    rstate_d = R_RESP;
                end
            end
            R_ADDR: if (m_arready[rsel_q]) begin
                marvalid_d = '0;
                mrready_d  = ONE << rsel_q;
                rstate_d   = R_DATA;
            end
`ifdef AXIL_ROUTER_TIMEOUT_EN
            else if (rto) begin
                marvalid_d = '0;
                rvalid_d   = 1'b1;
                rdata_d    = '0;
                rresp_d    = 2'b10;
                rstate_d   = R_RESP;
            end
`endif
            R_DATA: if (m_rvalid[rsel_q]) begin
                rdata_d   = m_rdata[rsel_q*DATA_W +: DATA_W];
                rresp_d   = m_rresp[rsel_q*2 +: 2];
                mrready_d = '0;
                rvalid_d  = 1'b1;
                rstate_d  = R_RESP;
            end
`ifdef AXIL_ROUTER_TIMEOUT_EN
            else if (rto) begin
                mrready_d = '0;
                rvalid_d  = 1'b1;
                rdata_d   = '0;
                rresp_d   = 2'b10;
                rstate_d  = R_RESP;
            end
`endif
            default: if (s_rready) begin
                rvalid_d  = 1'b0;
                arready_d = 1'b1;
                rstate_d  = R_IDLE;
            end
        endcase
    end

    always_comb begin
        wstate_d   = wstate_q;
        wsel_d     = wsel_q;
        whit_d     = whit_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        mawvalid_d = mawvalid_q;
        mwvalid_d  = mwvalid_q;
        mbready_d  = mbready_q;
        wdec       = decode(s_awaddr);
        aw_hs      = s_awvalid && awready_q;
        w_hs       = s_wvalid && wready_q;
        awv_n      = mawvalid_q & ~m_awready;
        wv_n       = mwvalid_q & ~m_wready;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs) begin
                    awready_d = 1'b0;
                    waddr_d   = s_awaddr;
                    waddr_d[SEL_HI:SEL_LO] = '0;
                    wsel_d    = wdec[IW-1:0];
                    whit_d    = wdec[IW];
                end
                if (w_hs) begin
                    wready_d = 1'b0;
                    wdata_d  = s_wdata;
                    wstrb_d  = s_wstrb;
                end
                // Leave idle once both address and data are held, whichever arrived last.
                if (!awready_d && !wready_d) begin
                    if (whit_d) begin
                        mawvalid_d = ONE << wsel_d;
                        mwvalid_d  = ONE << wsel_d;
                        wstate_d   = W_FWD;
                    end else begin
                        bvalid_d = 1'b1;
                        bresp_d  = 2'b11;
                        wstate_d = W_RESP;
                    end
                end
            end
            W_FWD: begin
                mawvalid_d = awv_n;
                mwvalid_d  = wv_n;
                if (awv_n == '0 && wv_n == '0) begin
                    mbready_d = ONE << wsel_q;
                    wstate_d  = W_BWAIT;
                end
`ifdef AXIL_ROUTER_TIMEOUT_EN
                else if (wto) begin
                    mawvalid_d = '0;
                    mwvalid_d  = '0;
                    bvalid_d   = 1'b1;
                    bresp_d    = 2'b10;
                    wstate_d   = W_RESP;
                end
`endif
            end
            W_BWAIT: if (m_bvalid[wsel_q]) begin
                bresp_d   = m_bresp[wsel_q*2 +: 2];
                mbready_d = '0;
                bvalid_d  = 1'b1;
                wstate_d  = W_RESP;
            end
`ifdef AXIL_ROUTER_TIMEOUT_EN
            else if (wto) begin
                mbready_d = '0;
                bvalid_d  = 1'b1;
                bresp_d   = 2'b10;
                wstate_d  = W_RESP;
            end
`endif
            default: if (s_bready) begin
                bvalid_d  = 1'b0;
                awready_d = 1'b1;
                wready_d  = 1'b1;
                wstate_d  = W_IDLE;
            end
        endcase
    end

`ifdef AXIL_ROUTER_TIMEOUT_EN
    // Counters restart on every state change and only run while waiting on a slave.
    always_comb begin
        rcnt_d = rcnt_q;
        wcnt_d = wcnt_q;
        if (rstate_d != rstate_q) rcnt_d = '0;
        else if (rstate_q == R_ADDR || rstate_q == R_DATA) rcnt_d = rcnt_q + 1'b1;
        if (wstate_d != wstate_q) wcnt_d = '0;
        else if (wstate_q == W_FWD || wstate_q == W_BWAIT) wcnt_d = wcnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt_q <= '0;
            wcnt_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
            wcnt_q <= wcnt_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q   <= R_IDLE;
            rsel_q     <= '0;
            raddr_q    <= '0;
            arready_q  <= 1'b1;
            marvalid_q <= '0;
            mrready_q  <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            wstate_q   <= W_IDLE;
            wsel_q     <= '0;
            whit_q     <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            mawvalid_q <= '0;
            mwvalid_q  <= '0;
            mbready_q  <= '0;
        end else begin
            rstate_q   <= rstate_d;
            rsel_q     <= rsel_d;
            raddr_q    <= raddr_d;
            arready_q  <= arready_d;
            marvalid_q <= marvalid_d;
            mrready_q  <= mrready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wstate_q   <= wstate_d;
            wsel_q     <= wsel_d;
            whit_q     <= whit_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            mawvalid_q <= mawvalid_d;
            mwvalid_q  <= mwvalid_d;
            mbready_q  <= mbready_d;
        end
    end

    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign m_araddr  = {N_SLAVES{raddr_q}};
    assign m_arvalid = marvalid_q;
    assign m_rready  = mrready_q;
    assign m_awaddr  = {N_SLAVES{waddr_q}};
    assign m_wdata   = {N_SLAVES{wdata_q}};
    assign m_wstrb   = {N_SLAVES{wstrb_q}};
    assign m_awvalid = mawvalid_q;
    assign m_wvalid  = mwvalid_q;
    assign m_bready  = mbready_q;
endmodule

// File: tb/tb_axil_addr_router.sv
// Directed bench for axil_addr_router: two slaves (IDs 0x00, 0xFF) modelled as always-ready responders.
module tb_axil_addr_router;
    localparam int N = 2, AW = 32, DW = 32;

    logic clk = 1'b0, rst = 1'b1;
    logic [AW-1:0] s_araddr = '0, s_awaddr = '0;
    logic s_arvalid = 0, s_rready = 0, s_awvalid = 0, s_wvalid = 0, s_bready = 0;
    logic [DW-1:0] s_wdata = '0;
    logic [DW/8-1:0] s_wstrb = '0;
    logic s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [DW-1:0] s_rdata;
    logic [1:0] s_rresp, s_bresp;
    logic [N*AW-1:0] m_araddr, m_awaddr;
    logic [N-1:0] m_arvalid, m_arready, m_rvalid, m_rready;
    logic [N-1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [N*DW-1:0] m_rdata, m_wdata;
    logic [N*DW/8-1:0] m_wstrb;
    logic [N*2-1:0] m_rresp, m_bresp;

    logic [N-1:0] ar_rdy = '1, r_en = '1, aw_rdy = '1, w_rdy = '1, b_en = '1;
    logic [N*DW-1:0] rbank = '0;
    logic saw_arv = 0;
    int checks = 0, errors = 0, lat;

    assign m_arready = ar_rdy;
    assign m_rvalid  = m_rready & r_en;
    assign m_rdata   = rbank;
    assign m_rresp   = '0;
    assign m_awready = aw_rdy;
    assign m_wready  = w_rdy;
    assign m_bvalid  = m_bready & b_en;
    assign m_bresp   = '0;

    axil_addr_router #(
`ifdef AXIL_ROUTER_TIMEOUT_EN
        .TIMEOUT(8)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (m_arvalid != '0) saw_arv <= 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts accept-relative cycles until the response valid rises (bounded).
    task automatic wait_r(inout int l);
        while (!s_rvalid && l < 30) begin step(); l++; end
    endtask
    task automatic wait_b(inout int l);
        while (!s_bvalid && l < 30) begin step(); l++; end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_arready", s_arready, 1);
        chk("rst_awready", s_awready, 1);
        chk("rst_wready", s_wready, 1);
        chk("rst_valids", {s_rvalid, s_bvalid, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}, 0);
        chk("rst_data", {s_rdata, s_rresp, s_bresp}, 0);

        // 0-wait read from slave 0
        rbank = {32'h0, 32'hDEADBEEF};
        s_araddr = 32'h0000_0010; s_arvalid = 1;
        step(); s_arvalid = 0;
        chk("rd0_arvalid", m_arvalid, 2'b01);
        chk("rd0_araddr", m_araddr, {32'h10, 32'h10});
        chk("rd0_arready_low", s_arready, 0);
        lat = 1; wait_r(lat);
        chk("rd0_latency", lat, 3);
        chk("rd0_rdata", s_rdata, 32'hDEADBEEF);
        chk("rd0_rresp", s_rresp, 0);
        s_rready = 1; step(); s_rready = 0;
        chk("rd0_done", {s_rvalid, s_arready}, 2'b01);

        // write to slave 1, W ahead of AW
        s_wdata = 32'h41; s_wstrb = 4'h1; s_wvalid = 1;
        step(); s_wvalid = 0;
        chk("wr1_w_only", {s_wready, s_awready, m_wvalid, m_awvalid}, 6'b010000);
        s_awaddr = 32'hFF00_0004; s_awvalid = 1;
        step(); s_awvalid = 0;
        chk("wr1_valids", {m_awvalid, m_wvalid}, 4'b1010);
        chk("wr1_awaddr", m_awaddr[63:32], 32'h4);
        chk("wr1_wdata", m_wdata[63:32], 32'h41);
        chk("wr1_wstrb", m_wstrb[7:4], 4'h1);
        lat = 1; wait_b(lat);
        chk("wr1_bvalid", s_bvalid, 1);
        chk("wr1_bresp", s_bresp, 0);
        s_bready = 1; step(); s_bready = 0;
        chk("wr1_done", {s_bvalid, s_awready, s_wready}, 3'b011);

        // unmapped read answered locally
        saw_arv = 0;
        s_araddr = 32'h1200_0000; s_arvalid = 1;
        step(); s_arvalid = 0;
        lat = 1; wait_r(lat);
        chk("miss_latency_le2", lat <= 2, 1);
        chk("miss_rresp", s_rresp, 2'b11);
        chk("miss_rdata", s_rdata, 0);
        chk("miss_no_arvalid", saw_arv, 0);
        s_rready = 1; step(); s_rready = 0;

        // concurrent read slave 0 and write slave 1, read response back-pressured
        rbank = {32'h0, 32'h12345678};
        s_araddr = 32'h0000_0020; s_arvalid = 1;
        s_awaddr = 32'hFF00_0008; s_awvalid = 1;
        s_wdata = 32'h99; s_wstrb = 4'hF; s_wvalid = 1;
        step(); s_arvalid = 0; s_awvalid = 0; s_wvalid = 0;
        chk("cc_valids", {m_arvalid, m_awvalid, m_wvalid}, 6'b011010);
        chk("cc_awaddr", m_awaddr[63:32], 32'h8);
        chk("cc_wdata", m_wdata[63:32], 32'h99);
        lat = 1; wait_r(lat);
        chk("cc_rd_latency", lat, 3);
        chk("cc_bvalid", {s_bvalid, s_bresp}, 3'b100);
        s_bready = 1; step(); s_bready = 0;
        chk("cc_wr_done", {s_bvalid, s_awready}, 2'b01);
        begin
            logic stable;
            stable = 1;
            for (int i = 0; i < 4; i++) begin
                if (!(s_rvalid === 1'b1 && s_rdata === 32'h12345678)) stable = 0;
                step();
            end
            chk("cc_rvalid_stable", {stable, s_rvalid, s_rdata}, {2'b11, 32'h12345678});
        end
        s_rready = 1; step(); s_rready = 0;
        chk("cc_rd_done", {s_rvalid, s_arready}, 2'b01);

        // reset while waiting in R_DATA
        r_en = '0;
        s_araddr = 32'h0000_0030; s_arvalid = 1;
        step(); s_arvalid = 0;
        step();
        chk("rstmid_rready", m_rready, 2'b01);
        rst = 1; step(); rst = 0;
        chk("rstmid_state", {m_rready, m_arvalid, s_arready, s_rvalid}, 6'b000010);
        r_en = '1;
        step(); step();
        chk("rstmid_no_rvalid", {s_rvalid, m_rready}, 0);

`ifdef AXIL_ROUTER_TIMEOUT_EN
        // slave 1 never answers B
        b_en = 2'b01;
        s_awaddr = 32'hFF00_000C; s_awvalid = 1;
        s_wdata = 32'h7; s_wvalid = 1;
        step(); s_awvalid = 0; s_wvalid = 0;
        lat = 1; wait_b(lat);
        chk("to_latency", lat, 10);
        chk("to_bresp", s_bresp, 2'b10);
        chk("to_bready_dropped", m_bready, 0);
        b_en = '1; step();
        chk("to_late_ignored", {m_bready, s_bvalid}, 3'b001);
        s_bready = 1; step(); s_bready = 0;
        chk("to_done", s_awready, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
